// File: rtl/ahb_arb_pkg.sv
// Shared encodings for the two-master AHB-Lite arbiter: HTRANS codes and arbiter FSM states.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS0 = 2'b01,
    ST_BUS1 = 2'b10
  } arb_state_e;

endpackage

// File: rtl/ahb_arb_pick.sv
// Winner selection between two requesters: fixed priority (M0 first) or round-robin
// against the last master granted. The result is only meaningful when someone requests.
module ahb_arb_pick (
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       mode_i,
  output logic       winner_o
);

  always_comb begin
    winner_o = 1'b0;
    if (!mode_i) begin
      winner_o = ~req_i[0];
    end else begin
      unique case (req_i)
        2'b01:   winner_o = 1'b0;
        2'b10:   winner_o = 1'b1;
        2'b11:   winner_o = ~last_i;
        default: winner_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/ahblite_arbiter_2m.sv
// Two-master AHB-Lite arbiter: registered grant FSM, address/data-phase owner tracking
// and slave-side multiplexing of the master request signals.
module ahblite_arbiter_2m
  import ahb_arb_pkg::*;
#(
  parameter int ARB_MODE       = 0,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [31:0] M0_HWDATA,
  input  logic        M0_HBUSREQ,
  input  logic        M0_HLOCK,
  output logic        M0_HGRANT,
  output logic        M0_HREADY,
  output logic [31:0] M0_HRDATA,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [31:0] M1_HWDATA,
  input  logic        M1_HBUSREQ,
  input  logic        M1_HLOCK,
  output logic        M1_HGRANT,
  output logic        M1_HREADY,
  output logic [31:0] M1_HRDATA,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  output logic        HMASTER,
  output logic        HMASTLOCK
);

  localparam logic DFLT = (DEFAULT_MASTER != 0);
  localparam logic MODE = (ARB_MODE != 0);

  arb_state_e state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_q, last_d;
  logic       hmaster_q, hmaster_d;
  logic       dmaster_q, dmaster_d;
  logic [1:0] req;
  logic       winner;
  logic       hold_bus;

  assign req = {M1_HBUSREQ, M0_HBUSREQ};

  ahb_arb_pick u_pick (
    .req_i    (req),
    .last_i   (last_q),
    .mode_i   (MODE),
    .winner_o (winner)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= ST_IDLE;
      grant_q   <= DFLT;
      last_q    <= 1'b1;
      hmaster_q <= DFLT;
      dmaster_q <= DFLT;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      hmaster_q <= hmaster_d;
      dmaster_q <= dmaster_d;
    end
  end

  // The holder keeps the bus while locked or in the middle of a requested burst.
  always_comb begin
    hold_bus = 1'b0;
    if (state_q != ST_IDLE) begin
      if (grant_q) hold_bus = M1_HLOCK | ((M1_HTRANS == HTRANS_SEQ) & M1_HBUSREQ);
      else         hold_bus = M0_HLOCK | ((M0_HTRANS == HTRANS_SEQ) & M0_HBUSREQ);
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    hmaster_d = hmaster_q;
    dmaster_d = dmaster_q;
    if (HREADY) begin
      hmaster_d = grant_q;
      dmaster_d = hmaster_q;
      if (!hold_bus) begin
        if (|req) begin
          grant_d = winner;
          state_d = winner ? ST_BUS1 : ST_BUS0;
        end else begin
          grant_d = DFLT;
          state_d = ST_IDLE;
        end
      end
      // Leaving park or switching owner counts as a new grant for round-robin fairness.
      if ((state_d != state_q) && (state_d != ST_IDLE)) last_d = grant_d;
    end
  end

  assign M0_HGRANT = ~grant_q;
  assign M1_HGRANT = grant_q;

  assign HADDR     = hmaster_q ? M1_HADDR  : M0_HADDR;
  assign HTRANS    = hmaster_q ? M1_HTRANS : M0_HTRANS;
  assign HWRITE    = hmaster_q ? M1_HWRITE : M0_HWRITE;
  assign HSIZE     = hmaster_q ? M1_HSIZE  : M0_HSIZE;
  assign HMASTLOCK = hmaster_q ? M1_HLOCK  : M0_HLOCK;
  assign HWDATA    = dmaster_q ? M1_HWDATA : M0_HWDATA;
  assign HMASTER   = hmaster_q;

  assign M0_HREADY = HREADY;
  assign M1_HREADY = HREADY;
  assign M0_HRDATA = HRDATA;
  assign M1_HRDATA = HRDATA;

endmodule

// File: tb/tb_ahblite_arbiter_2m.sv
// Directed bench: a fixed-priority and a round-robin arbiter share stimulus; a vector
// table covers arbitration, then hand-written sequences cover bursts, lock, waits and reset.
module tb_ahblite_arbiter_2m;

  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h1000_2000;
  localparam logic [31:0] D0 = 32'h1111_1111;
  localparam logic [31:0] D1 = 32'hA5A5_5A5A;

  logic        hclk, hresetn;
  logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata, hrdata;
  logic [1:0]  m0_htrans, m1_htrans;
  logic        m0_hwrite, m1_hwrite, m0_hbusreq, m1_hbusreq, m0_hlock, m1_hlock, hready;
  logic [2:0]  m0_hsize, m1_hsize;

  logic        fp_m0_hgrant, fp_m1_hgrant, fp_m0_hready, fp_m1_hready;
  logic [31:0] fp_m0_hrdata, fp_m1_hrdata, fp_haddr, fp_hwdata;
  logic [1:0]  fp_htrans;
  logic        fp_hwrite, fp_hmaster, fp_hmastlock;
  logic [2:0]  fp_hsize;

  logic        rr_m0_hgrant, rr_m1_hgrant, rr_m0_hready, rr_m1_hready;
  logic [31:0] rr_m0_hrdata, rr_m1_hrdata, rr_haddr, rr_hwdata;
  logic [1:0]  rr_htrans;
  logic        rr_hwrite, rr_hmaster, rr_hmastlock;
  logic [2:0]  rr_hsize;

  int nvec  = 0;
  int nmiss = 0;

  ahblite_arbiter_2m #(.ARB_MODE(0), .DEFAULT_MASTER(0)) u_fp (
    .HCLK(hclk), .HRESETn(hresetn),
    .M0_HADDR(m0_haddr), .M0_HTRANS(m0_htrans), .M0_HWRITE(m0_hwrite), .M0_HSIZE(m0_hsize),
    .M0_HWDATA(m0_hwdata), .M0_HBUSREQ(m0_hbusreq), .M0_HLOCK(m0_hlock),
    .M0_HGRANT(fp_m0_hgrant), .M0_HREADY(fp_m0_hready), .M0_HRDATA(fp_m0_hrdata),
    .M1_HADDR(m1_haddr), .M1_HTRANS(m1_htrans), .M1_HWRITE(m1_hwrite), .M1_HSIZE(m1_hsize),
    .M1_HWDATA(m1_hwdata), .M1_HBUSREQ(m1_hbusreq), .M1_HLOCK(m1_hlock),
    .M1_HGRANT(fp_m1_hgrant), .M1_HREADY(fp_m1_hready), .M1_HRDATA(fp_m1_hrdata),
    .HADDR(fp_haddr), .HTRANS(fp_htrans), .HWRITE(fp_hwrite), .HSIZE(fp_hsize),
    .HWDATA(fp_hwdata), .HREADY(hready), .HRDATA(hrdata),
    .HMASTER(fp_hmaster), .HMASTLOCK(fp_hmastlock)
  );

  ahblite_arbiter_2m #(.ARB_MODE(1), .DEFAULT_MASTER(0)) u_rr (
    .HCLK(hclk), .HRESETn(hresetn),
    .M0_HADDR(m0_haddr), .M0_HTRANS(m0_htrans), .M0_HWRITE(m0_hwrite), .M0_HSIZE(m0_hsize),
    .M0_HWDATA(m0_hwdata), .M0_HBUSREQ(m0_hbusreq), .M0_HLOCK(m0_hlock),
    .M0_HGRANT(rr_m0_hgrant), .M0_HREADY(rr_m0_hready), .M0_HRDATA(rr_m0_hrdata),
    .M1_HADDR(m1_haddr), .M1_HTRANS(m1_htrans), .M1_HWRITE(m1_hwrite), .M1_HSIZE(m1_hsize),
    .M1_HWDATA(m1_hwdata), .M1_HBUSREQ(m1_hbusreq), .M1_HLOCK(m1_hlock),
    .M1_HGRANT(rr_m1_hgrant), .M1_HREADY(rr_m1_hready), .M1_HRDATA(rr_m1_hrdata),
    .HADDR(rr_haddr), .HTRANS(rr_htrans), .HWRITE(rr_hwrite), .HSIZE(rr_hsize),
    .HWDATA(rr_hwdata), .HREADY(hready), .HRDATA(hrdata),
    .HMASTER(rr_hmaster), .HMASTLOCK(rr_hmastlock)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmiss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic set_req(input logic r0, input logic r1, input logic [1:0] t0,
                         input logic [1:0] t1, input logic l0, input logic l1);
    m0_hbusreq = r0; m1_hbusreq = r1;
    m0_htrans  = t0; m1_htrans  = t1;
    m0_hlock   = l0; m1_hlock   = l1;
  endtask

  typedef struct {
    logic       r0, r1;
    logic [1:0] t0;
    logic       rdy;
    logic       fg0, fhm, rg0, rhm, rdm;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    hresetn   = 1'b0;
    m0_haddr  = A0;    m1_haddr  = A1;
    m0_hwdata = D0;    m1_hwdata = D1;
    m0_hwrite = 1'b0;  m1_hwrite = 1'b0;
    m0_hsize  = 3'd2;  m1_hsize  = 3'd1;
    hready    = 1'b1;  hrdata    = 32'hDEAD_BEEF;
    set_req(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

    tick();
    chk("rst_haddr_default", fp_haddr, A0);
    chk("rst_hsize_default", {29'd0, fp_hsize}, 32'd2);
    tick();
    hresetn = 1'b1;
    chk("rst_m0_grant", {31'd0, fp_m0_hgrant}, 32'd1);
    chk("rst_m1_grant", {31'd0, fp_m1_hgrant}, 32'd0);
    chk("rst_hmaster", {31'd0, fp_hmaster}, 32'd0);
    chk("rst_htrans", {30'd0, fp_htrans}, 32'd0);
    chk("rdata_bcast_m1", fp_m1_hrdata, 32'hDEAD_BEEF);
    chk("ready_bcast_m0", {31'd0, fp_m0_hready}, 32'd1);

    for (int i = 0; i < 10; i++) begin
      set_req(vecs[i].r0, vecs[i].r1, vecs[i].t0, 2'b00, 1'b0, 1'b0);
      hready = vecs[i].rdy;
      tick();
      chk($sformatf("v%0d fp_m0_grant", i), {31'd0, fp_m0_hgrant}, {31'd0, vecs[i].fg0});
      chk($sformatf("v%0d fp_m1_grant", i), {31'd0, fp_m1_hgrant}, {31'd0, ~vecs[i].fg0});
      chk($sformatf("v%0d fp_hmaster", i), {31'd0, fp_hmaster}, {31'd0, vecs[i].fhm});
      chk($sformatf("v%0d rr_m0_grant", i), {31'd0, rr_m0_hgrant}, {31'd0, vecs[i].rg0});
      chk($sformatf("v%0d rr_hmaster", i), {31'd0, rr_hmaster}, {31'd0, vecs[i].rhm});
      chk($sformatf("v%0d rr_haddr", i), rr_haddr, vecs[i].rhm ? A1 : A0);
      chk($sformatf("v%0d rr_htrans", i), {30'd0, rr_htrans},
          {30'd0, vecs[i].rhm ? 2'b00 : vecs[i].t0});
      chk($sformatf("v%0d rr_hwdata", i), rr_hwdata, vecs[i].rdm ? D1 : D0);
    end
    hready = 1'b1;

    // Fixed priority: M0 keeps the bus against a constant M1 request.
    set_req(1'b1, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("fp10 c%0d m0_grant", c), {31'd0, fp_m0_hgrant}, 32'd1);
      chk($sformatf("fp10 c%0d m1_grant", c), {31'd0, fp_m1_hgrant}, 32'd0);
    end
    set_req(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    tick(); tick();

    // M1 four-beat burst; M0 request raised on beat 2 must wait for the last SEQ.
    set_req(1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();
    chk("burst_grant_m1", {31'd0, fp_m1_hgrant}, 32'd1);
    set_req(1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0);
    tick();
    chk("burst_owner_m1", {31'd0, fp_hmaster}, 32'd1);
    chk("burst_htrans_ns", {30'd0, fp_htrans}, 32'd2);
    set_req(1'b1, 1'b1, 2'b00, 2'b11, 1'b0, 1'b0);
    tick();
    chk("burst_b2_m1_grant", {31'd0, fp_m1_hgrant}, 32'd1);
    chk("burst_b2_htrans", {30'd0, fp_htrans}, 32'd3);
    tick();
    chk("burst_b3_m1_grant", {31'd0, fp_m1_hgrant}, 32'd1);
    set_req(1'b1, 1'b0, 2'b00, 2'b11, 1'b0, 1'b0);
    tick();
    chk("burst_end_m0_grant", {31'd0, fp_m0_hgrant}, 32'd1);
    chk("burst_end_owner_m1", {31'd0, fp_hmaster}, 32'd1);
    set_req(1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0);
    tick();
    chk("burst_after_owner_m0", {31'd0, fp_hmaster}, 32'd0);
    chk("burst_after_htrans", {30'd0, fp_htrans}, 32'd2);
    set_req(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    tick(); tick();

    // Locked M1 holds the bus against higher-priority M0.
    set_req(1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1);
    tick();
    chk("lock_grant_m1", {31'd0, fp_m1_hgrant}, 32'd1);
    set_req(1'b1, 1'b1, 2'b00, 2'b10, 1'b0, 1'b1);
    tick();
    chk("lock_c1_m1_grant", {31'd0, fp_m1_hgrant}, 32'd1);
    chk("lock_c1_mastlock", {31'd0, fp_hmastlock}, 32'd1);
    tick();
    chk("lock_c2_m1_grant", {31'd0, fp_m1_hgrant}, 32'd1);
    chk("lock_c2_mastlock", {31'd0, fp_hmastlock}, 32'd1);
    set_req(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();
    chk("lock_rel_m0_grant", {31'd0, fp_m0_hgrant}, 32'd1);
    chk("lock_rel_mastlock", {31'd0, fp_hmastlock}, 32'd0);
    set_req(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();
    chk("lock_rel_owner_m0", {31'd0, fp_hmaster}, 32'd0);
    tick();

    // M1 write with three wait states; a fresh M1 request during the wait must not move grant.
    set_req(1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();
    m1_hwrite = 1'b1;
    set_req(1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0);
    tick();
    chk("wr_addr_owner", {31'd0, fp_hmaster}, 32'd1);
    chk("wr_hwrite", {31'd0, fp_hwrite}, 32'd1);
    set_req(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();
    chk("wr_data_hwdata", fp_hwdata, D1);
    hready = 1'b0;
    set_req(1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
    for (int w = 0; w < 3; w++) begin
      tick();
      chk($sformatf("wait%0d hmaster", w), {31'd0, fp_hmaster}, 32'd1);
      chk($sformatf("wait%0d hwdata", w), fp_hwdata, D1);
      chk($sformatf("wait%0d m0_grant", w), {31'd0, fp_m0_hgrant}, 32'd1);
      chk($sformatf("wait%0d m1_ready", w), {31'd0, fp_m1_hready}, 32'd0);
    end
    hready = 1'b1;
    set_req(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();
    chk("wait_done_hmaster", {31'd0, fp_hmaster}, 32'd0);
    chk("wait_done_hwdata", fp_hwdata, D1);
    chk("wait_done_m0_grant", {31'd0, fp_m0_hgrant}, 32'd1);
    tick();
    chk("wait_next_hwdata", fp_hwdata, D0);
    m1_hwrite = 1'b0;

    // Asynchronous reset while M1 owns the bus.
    set_req(1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();
    set_req(1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0);
    tick();
    chk("pre_rst_owner_m1", {31'd0, fp_hmaster}, 32'd1);
    #2;
    hresetn = 1'b0;
    #1;
    chk("async_rst_m0_grant", {31'd0, fp_m0_hgrant}, 32'd1);
    chk("async_rst_hmaster", {31'd0, fp_hmaster}, 32'd0);
    chk("async_rst_haddr", fp_haddr, A0);
    chk("async_rst_rr_grant", {31'd0, rr_m0_hgrant}, 32'd1);
    set_req(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();
    hresetn = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule

// File: doc/ahblite_arbiter_2m.md
AHBLITE_ARBITER_2M -- requirements
Module: ahblite_arbiter_2m

Interface
REQ-001 Parameter ARB_MODE, default 0, meaning 0 = fixed priority (M0 wins), 1 = round-robin.
REQ-002 Parameter DEFAULT_MASTER, default 0, meaning master parked on the bus when nobody requests.
REQ-003 The block SHALL use one clock, HCLK, and an asynchronous, active-low reset, HRESETn.
REQ-004 The ports SHALL be as listed below; each Mn_ line exists for both n=0 (CPU) and n=1 (DMA).
- HCLK  in  1  bus clock
- HRESETn  in  1  async active-low reset
- Mn_HADDR  in  32  master address
- Mn_HTRANS  in  2  master transfer type
- Mn_HWRITE  in  1  master write
- Mn_HSIZE  in  3  master size
- Mn_HWDATA  in  32  master write data
- Mn_HBUSREQ  in  1  bus request
- Mn_HLOCK  in  1  locked-sequence request
- Mn_HGRANT  out  1  grant
- Mn_HREADY  out  1  ready to master
- Mn_HRDATA  out  32  read data to master
- HADDR  out  32  slave-side address
- HTRANS  out  2  slave-side transfer type
- HWRITE  out  1  slave-side write
- HSIZE  out  3  slave-side size
- HWDATA  out  32  slave-side write data
- HREADY  in  1  bus ready from slave mux
- HRDATA  in  32  bus read data
- HMASTER  out  1  address-phase owner
- HMASTLOCK  out  1  owner lock

Function
REQ-005 FSM states SHALL be IDLE (parked, no request), BUS0 (M0 granted) and BUS1 (M1 granted); exactly one Mn_HGRANT SHALL be high at all times.
REQ-006 Grant SHALL be registered and SHALL update only on a rising HCLK edge with HREADY=1; with HREADY=0 grant, state and owners SHALL hold.
REQ-007 Grant SHALL be retained by the current holder while its HLOCK=1, or while its HTRANS=SEQ and its HBUSREQ=1 (mid-burst); otherwise the arbiter SHALL re-arbitrate.
REQ-008 Re-arbitration with ARB_MODE=0 SHALL grant M0 if M0_HBUSREQ=1, else M1 if M1_HBUSREQ=1, else DEFAULT_MASTER (state IDLE).
REQ-009 Re-arbitration with ARB_MODE=1 SHALL grant the requester that is not last_granted when both request; with one request it SHALL grant that master; with none it SHALL park on DEFAULT_MASTER.
REQ-010 last_granted SHALL update only on a grant change to a requesting master.
REQ-011 Address owner HMASTER SHALL load the granted master on each edge with HREADY=1, giving 1 edge from grant to address ownership.
REQ-012 Data-phase owner dmaster SHALL load HMASTER on each edge with HREADY=1.
REQ-013 HADDR, HTRANS, HWRITE and HSIZE SHALL be combinationally muxed from HMASTER; HWDATA SHALL be muxed from dmaster.
REQ-014 HMASTLOCK SHALL equal the HLOCK of the HMASTER master.
REQ-015 Mn_HREADY SHALL equal HREADY and Mn_HRDATA SHALL equal HRDATA, broadcast to both masters.
REQ-016 Latency: request on an idle bus with HREADY=1 SHALL produce the grant at edge+1 and ownership at edge+2.
REQ-017 Simultaneous requests SHALL be resolved per REQ-008/009 in the same cycle.
REQ-018 Request withdrawal during a waited transfer (HREADY=0) SHALL take effect at the first HREADY=1 edge.
REQ-019 A non-owner's HTRANS SHALL never reach the slave side.

Reset
REQ-020 On HRESETn=0, asynchronously: state=IDLE; grant, HMASTER and dmaster = DEFAULT_MASTER; last_granted = 1; with DEFAULT_MASTER=0 this gives M0_HGRANT=1, M1_HGRANT=0.
REQ-021 Reset asserted mid-transfer SHALL abandon ownership with no completion obligation.
REQ-022 Slave-side outputs during reset SHALL reflect the DEFAULT_MASTER inputs.

Structure
REQ-023 Shared package ahb_arb_pkg SHALL hold the HTRANS encodings (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11) and the FSM state encodings.
REQ-024 The priority/round-robin selection SHALL be a sub-module ahb_arb_pick (inputs: requests, last_granted, mode; output: winner).
REQ-025 Target size SHALL be 150-300 lines of RTL.

Verification
REQ-026 Reset release with no requests -> M0_HGRANT=1, HMASTER=0, HTRANS=00.
REQ-027 ARB_MODE=0, both HBUSREQ=1 for 10 cycles -> M0 holds grant throughout; M1_HGRANT stays 0.
REQ-028 ARB_MODE=1, both requesting, single transfers -> grant alternates M0/M1 every arbitration; HWDATA tracks dmaster one HREADY-edge behind HADDR.
REQ-029 M1 4-beat INCR burst (NONSEQ, SEQ, SEQ, SEQ) with M0_HBUSREQ raised at beat 2 -> M1 keeps grant through the last SEQ; M0 granted next edge.
REQ-030 M1_HLOCK=1 with M0 requesting, ARB_MODE=0 -> M1 retains grant and HMASTLOCK=1 until M1_HLOCK=0.
REQ-031 HREADY held 0 for 3 cycles during M1 write -> HMASTER, dmaster and HWDATA=0xA5A5_5A5A stable until HREADY=1.
